txt_raster: RTL and testbench

//  Parametrised text-mode rasteriser: walks a COLS x ROWS character grid, fetches each

---
 rtl/txt_raster.sv | 173 +++++++++++++++++
 tb/tb_txt_raster.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/txt_raster.sv
// Text-mode rasteriser: per scanline/cell fetches code then glyph row, writes CELL_W pixels; 3+CELL_W cycles per cell.
// fb_ready low stalls DRAW with outputs held; optional flash phase counter under `TXT_FLASH_EN.
module txt_raster #(
    parameter int          COLS      = 40,
    parameter int          ROWS      = 24,
    parameter int          CELL_W    = 7,
    parameter int          CELL_H    = 8,
    parameter logic [15:0] TXT_BASE  = 16'h400,
    parameter int          ADDR_MODE = 1,
    parameter int          FB_AW     = 16,
    parameter int          PIX_W     = 24,
    parameter logic [PIX_W-1:0] FG   = 24'hFFFFFF,
    parameter logic [PIX_W-1:0] BG   = 24'h000000,
    parameter int          FLASH_FR  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   txt_adr,
    input  logic [7:0]                    txt_q,
    output logic [8+$clog2(CELL_H)-1:0]   crom_adr,
    input  logic [7:0]                    crom_q,
    output logic                          fb_we,
    output logic [FB_AW-1:0]              fb_adr,
    output logic [PIX_W-1:0]              fb_d,
    input  logic                          fb_ready
);
    localparam int NLINES = ROWS * CELL_H;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int Y_W    = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int DX_W   = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CA_W   = 8 + $clog2(CELL_H);

    typedef enum logic [2:0] {S_IDLE, S_TADR, S_TCAP, S_GCAP, S_DRAW, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [DX_W-1:0]  dx_q, dx_d;
    logic [7:0]       code_q, code_d;
    logic [7:0]       glyph_q, glyph_d;
    logic             dx_last, col_last, y_last;
    logic             flash_inv, inv;
    logic [31:0]      row, dot_y;

`ifdef TXT_FLASH_EN
    localparam int FR_W = (FLASH_FR > 1) ? $clog2(FLASH_FR) : 1;
    logic [FR_W-1:0]  frm_q, frm_d;
    logic             phase_q, phase_d;

    // Phase only changes in DONE, so it is constant for the whole of a frame.
    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (state_q == S_DONE) begin
            if (frm_q == FR_W'(FLASH_FR - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign flash_inv = phase_q;
`else
    assign flash_inv = 1'b1;
`endif

    assign dx_last  = (dx_q == DX_W'(CELL_W - 1));
    assign col_last = (col_q == COL_W'(COLS - 1));
    assign y_last   = (y_q == Y_W'(NLINES - 1));
    assign row      = 32'(y_q) / CELL_H;
    assign dot_y    = 32'(y_q) % CELL_H;

    always_comb begin
        if (code_q[7])      inv = 1'b0;
        else if (code_q[6]) inv = flash_inv;
        else                inv = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_TADR;
            S_TADR: state_d = S_TCAP;
            S_TCAP: state_d = S_GCAP;
            S_GCAP: state_d = S_DRAW;
            S_DRAW: if (fb_ready && dx_last) state_d = (col_last && y_last) ? S_DONE : S_TADR;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_d   = col_q;
        y_d     = y_q;
        dx_d    = dx_q;
        code_d  = code_q;
        glyph_d = glyph_q;
        if (state_q == S_TCAP) code_d = txt_q;
        if (state_q == S_GCAP) glyph_d = inv ? ~crom_q : crom_q;
        if (state_q == S_DRAW && fb_ready) begin
            if (dx_last) begin
                dx_d = '0;
                if (col_last) begin
                    col_d = '0;
                    y_d   = y_last ? '0 : y_q + Y_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                dx_d = dx_q + DX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q   <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            code_q  <= '0;
            glyph_q <= '0;
        end else begin
            col_q   <= col_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            code_q  <= code_d;
            glyph_q <= glyph_d;
        end
    end

    // Outputs are zero outside their owning state so idle/reset values are all-zero.
    always_comb begin
        busy     = (state_q == S_TADR) || (state_q == S_TCAP) ||
                   (state_q == S_GCAP) || (state_q == S_DRAW);
        done     = (state_q == S_DONE);
        fb_we    = (state_q == S_DRAW);
        txt_adr  = '0;
        crom_adr = '0;
        fb_adr   = '0;
        fb_d     = '0;
        if (state_q == S_TADR) begin
            if (ADDR_MODE == 1)
                txt_adr = 16'(32'(TXT_BASE) + 128 * (row % 8) + 40 * (row / 8) + 32'(col_q));
            else
                txt_adr = 16'(32'(TXT_BASE) + row * COLS + 32'(col_q));
        end
        if (state_q == S_TCAP) crom_adr = CA_W'(32'(txt_q) * CELL_H + dot_y);
        if (state_q == S_DRAW) begin
            fb_adr = FB_AW'(32'(y_q) * (COLS * CELL_W) + 32'(col_q) * CELL_W + 32'(dx_q));
            fb_d   = glyph_q[3'(32'(CELL_W - 1) - 32'(dx_q))] ? FG : BG;
        end
    end
endmodule

// File: tb/tb_txt_raster.sv
module tb_txt_raster;
    localparam int A_COLS = 3, A_ROWS = 2, A_CW = 5, A_CH = 4, A_FBAW = 6, A_PW = 12, A_FR = 2;
    localparam logic [15:0]     A_BASE = 16'h0100;
    localparam logic [A_PW-1:0] A_FG = 12'hABC, A_BG = 12'h123;
    localparam int A_LINES = A_ROWS * A_CH;
    localparam int A_PIX   = A_COLS * A_CW * A_LINES;
    localparam int A_CYC   = A_COLS * A_ROWS * A_CH * (3 + A_CW);
    localparam int B_CYC   = 40 * 24 * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, fb_ready_a, fb_ready_b;
    logic [7:0] txt_q_a, crom_q_a, txt_q_b, crom_q_b;
    logic busy_a, done_a, fb_we_a, busy_b, done_b, fb_we_b;
    logic [15:0] txt_adr_a, txt_adr_b;
    logic [9:0]  crom_adr_a;
    logic [7:0]  crom_adr_b;
    logic [A_FBAW-1:0] fb_adr_a;
    logic [A_PW-1:0]   fb_d_a;
    logic [15:0] fb_adr_b;
    logic [23:0] fb_d_b;

    txt_raster #(.COLS(A_COLS), .ROWS(A_ROWS), .CELL_W(A_CW), .CELL_H(A_CH), .TXT_BASE(A_BASE),
                 .ADDR_MODE(0), .FB_AW(A_FBAW), .PIX_W(A_PW), .FG(A_FG), .BG(A_BG), .FLASH_FR(A_FR))
    u_a (.clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
         .txt_adr(txt_adr_a), .txt_q(txt_q_a), .crom_adr(crom_adr_a), .crom_q(crom_q_a),
         .fb_we(fb_we_a), .fb_adr(fb_adr_a), .fb_d(fb_d_a), .fb_ready(fb_ready_a));

    txt_raster #(.COLS(40), .ROWS(24), .CELL_W(1), .CELL_H(1), .ADDR_MODE(1))
    u_b (.clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
         .txt_adr(txt_adr_b), .txt_q(txt_q_b), .crom_adr(crom_adr_b), .crom_q(crom_q_b),
         .fb_we(fb_we_b), .fb_adr(fb_adr_b), .fb_d(fb_d_b), .fb_ready(fb_ready_b));

    logic [7:0] txt_mem [0:65535];
    logic [7:0] crom_a  [0:1023];

    logic [A_FBAW-1:0] got_adr[$], exp_adr[$];
    logic [A_PW-1:0]   got_dat[$], exp_dat[$];
    logic [15:0]       got_tadr_b[$];
    int stalls, unstable, ncmp, nfail, frames, cyc;
    bit phase;
    logic held_vld;
    logic [A_FBAW-1:0] held_adr;
    logic [A_PW-1:0]   held_dat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the write port and memories at negedge, return memory data after the edge.
    task automatic tick();
        logic [15:0] ta_a, ta_b;
        logic [9:0]  ca_a;
        @(negedge clk);
        if (reset) begin
            if (held_vld && !(fb_we_a && fb_adr_a == held_adr && fb_d_a == held_dat)) unstable++;
            held_vld = fb_we_a && !fb_ready_a;
            held_adr = fb_adr_a;
            held_dat = fb_d_a;
            if (fb_we_a && !fb_ready_a) stalls++;
            if (fb_we_a && fb_ready_a) begin
                got_adr.push_back(fb_adr_a);
                got_dat.push_back(fb_d_a);
            end
            if (txt_adr_b != 16'h0) got_tadr_b.push_back(txt_adr_b);
        end else begin
            held_vld = 1'b0;
        end
        ta_a = txt_adr_a;
        ca_a = crom_adr_a;
        ta_b = txt_adr_b;
        @(posedge clk);
        #1;
        txt_q_a  = txt_mem[ta_a];
        crom_q_a = crom_a[ca_a];
        txt_q_b  = txt_mem[ta_b];
    endtask

    // Reference frame: every pixel of every scanline, derived straight from the grid rules.
    task automatic build_expected();
        exp_adr.delete();
        exp_dat.delete();
        for (int y = 0; y < A_LINES; y++) begin
            for (int c = 0; c < A_COLS; c++) begin
                logic [7:0] code, g;
                bit inv;
                code = txt_mem[int'(A_BASE) + (y / A_CH) * A_COLS + c];
                g    = crom_a[int'(code) * A_CH + y % A_CH];
                if (code[7])      inv = 1'b0;
`ifdef TXT_FLASH_EN
                else if (code[6]) inv = phase;
`else
                else if (code[6]) inv = 1'b1;
`endif
                else              inv = 1'b1;
                for (int x = 0; x < A_CW; x++) begin
                    exp_adr.push_back(A_FBAW'(y * A_COLS * A_CW + c * A_CW + x));
                    exp_dat.push_back((g[A_CW-1-x] ^ inv) ? A_FG : A_BG);
                end
            end
        end
    endtask

    task automatic fill_text(input bit rnd, input logic [7:0] code, input logic [7:0] glyph);
        for (int i = 0; i < A_COLS * A_ROWS; i++)
            txt_mem[int'(A_BASE) + i] = rnd ? 8'($urandom) : code;
        for (int i = 0; i < 1024; i++)
            crom_a[i] = rnd ? 8'($urandom) : glyph;
    endtask

    task automatic run_frame_a(input bit stall, input bit start_mid);
        int n;
        build_expected();
        got_adr.delete();
        got_dat.delete();
        stalls = 0;
        unstable = 0;
        start_a = 1'b1;
        fb_ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_after_start", busy_a, 1);
        cyc = 0;
        while (!done_a && cyc < 3000) begin
            fb_ready_a = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_a = (start_mid && cyc == 20);
            tick();
            cyc++;
        end
        start_a = 1'b0;
        fb_ready_a = 1'b1;
        chk("done_seen", done_a, 1);
        chk("frame_cycles", cyc, A_CYC + stalls);
        chk("busy_at_done", busy_a, 0);
        chk("write_count", got_adr.size(), A_PIX);
        chk("stall_hold", unstable, 0);
        n = (got_adr.size() < exp_adr.size()) ? got_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("fb_adr[%0d]", i), got_adr[i], exp_adr[i]);
            chk($sformatf("fb_d[%0d]", i), got_dat[i], exp_dat[i]);
        end
        frames++;
        if (frames % A_FR == 0) phase = ~phase;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("done_one_cycle", done_a, 0);
        chk("start_at_done_ignored", busy_a, 0);
        tick();
        chk("idle_after_done", busy_a, 0);
    endtask

    initial begin
        ncmp = 0; nfail = 0; frames = 0; phase = 1'b0; held_vld = 1'b0;
        for (int i = 0; i < 65536; i++) txt_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) crom_a[i] = 8'($urandom);
        reset = 1'b0; start_a = 1'b1; start_b = 1'b1; fb_ready_a = 1'b1; fb_ready_b = 1'b1;
        txt_q_a = 8'h0; crom_q_a = 8'h0; txt_q_b = 8'h0; crom_q_b = 8'hFF;

        repeat (3) tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_fb_we", fb_we_a, 0);
        chk("rst_txt_adr", txt_adr_a, 0);
        chk("rst_crom_adr", crom_adr_a, 0);
        chk("rst_fb_adr", fb_adr_a, 0);
        chk("rst_fb_d", fb_d_a, 0);
        chk("rst_busy_b", busy_b, 0);
        start_a = 1'b0; start_b = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_after_release", busy_a, 0);

        fill_text(1'b0, 8'hC1, 8'h55); run_frame_a(1'b0, 1'b0);
        fill_text(1'b0, 8'h01, 8'h55); run_frame_a(1'b0, 1'b0);
        fill_text(1'b1, 8'h00, 8'h00); run_frame_a(1'b1, 1'b1);
        fill_text(1'b1, 8'h00, 8'h00); run_frame_a(1'b1, 1'b0);
        fill_text(1'b0, 8'h41, 8'h3A); run_frame_a(1'b0, 1'b0);
        fill_text(1'b0, 8'h41, 8'h3A); run_frame_a(1'b1, 1'b0);

        // Abandon a frame mid-DRAW with reset.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!fb_we_a && cyc < 50) begin tick(); cyc++; end
        chk("reached_draw", fb_we_a, 1);
        reset = 1'b0;
        #1;
        chk("async_fb_we_drop", fb_we_a, 0);
        chk("async_busy_drop", busy_a, 0);
        chk("async_fb_d_clear", fb_d_a, 0);
        tick();
        chk("no_done_in_reset", done_a, 0);
        reset = 1'b1;
        phase = 1'b0;
        frames = 0;
        tick();
        chk("no_done_after_abort", done_a, 0);
        fill_text(1'b1, 8'h00, 8'h00); run_frame_a(1'b1, 1'b0);

        // Interleaved addressing on a full 40x24 grid with single-dot cells.
        got_tadr_b.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 6000) begin tick(); cyc++; end
        chk("b_done_seen", done_b, 1);
        chk("b_frame_cycles", cyc, B_CYC);
        chk("b_txt_adr_count", got_tadr_b.size(), 960);
        if (got_tadr_b.size() == 960) begin
            chk("b_row8_col0", got_tadr_b[320], 16'h428);
            chk("b_row23_col39", got_tadr_b[959], 16'h7F7);
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 40; c++)
                    chk($sformatf("b_txt_adr_r%0d_c%0d", r, c), got_tadr_b[r * 40 + c],
                        16'(16'h400 + 128 * (r % 8) + 40 * (r / 8) + c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
